// File: rtl/nios2cpu_mul_seq.sv
// Sequential 32x32 low-word multiplier driving an external 32x16 cell twice.
// MUL_SEQ_ZERO_BYPASS_EN: zero operands skip the cell and finish at accept.
module nios2cpu_mul_seq #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(CELL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [31:0] res_q, res_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        zero_in;

`ifdef MUL_SEQ_ZERO_BYPASS_EN
  assign zero_in = (in_src1 == '0) || (in_src2 == '0);
`else
  assign zero_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    p_lo_d  = p_lo_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (zero_in) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            src1_d  = in_src1;
            src2_d  = in_src2;
            cnt_d   = CNT_INIT;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (cnt_q == '0) begin
          p_lo_d  = mul_cell_result;
          // Swap halves so the cell sees the upper multiplier half next.
          src2_d  = {src2_q[15:0], src2_q[31:16]};
          cnt_d   = CNT_INIT;
          state_d = HI;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HI: begin
        if (cnt_q == '0) begin
          res_d   = p_lo_q + {mul_cell_result[15:0], 16'h0000};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      p_lo_q      <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      p_lo_q      <= p_lo_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;

endmodule

// File: doc/nios2cpu_mul_seq.md
NIOS2CPU_MUL_SEQ -- requirements
Module: nios2cpu_mul_seq

Interface
REQ-001 The block SHALL have one parameter, CELL_LATENCY, default 1: the number of clock edges from the mul_src1/mul_src2 operands being driven to mul_cell_result being valid. The legal range is 1..3.
REQ-002 The block SHALL have these ports, in this order:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand pair is offered.
- in_ready  output  1  the block accepts an operand pair.
- in_src1  input  32  multiplicand.
- in_src2  input  32  multiplier.
- out_valid  output  1  out_result is valid.
- out_ready  input  1  the consumer takes the result.
- out_result  output  32  low 32 bits of in_src1*in_src2.
- mul_src1  output  32  operand A to the 32x16 multiply cell.
- mul_src2  output  32  operand B to the cell; the cell uses bits [15:0] only.
- mul_cell_result  input  32  cell output, equal to mul_src1*mul_src2[15:0] mod 2^32.
REQ-003 Every output SHALL be driven from a register. No input SHALL have a combinational path to any output.

Function
REQ-004 The FSM SHALL have four states: IDLE, LO, HI and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE.
REQ-006 Accept SHALL occur on an edge where in_valid and in_ready are both 1. On accept:
- latch A = in_src1 and B = in_src2;
- set mul_src1 = A and mul_src2 = B;
- set a wait counter to CELL_LATENCY-1;
- go to LO.
REQ-007 In LO the counter SHALL decrement each cycle. On the edge where the counter reaches 0:
- capture P_lo = mul_cell_result;
- set mul_src2 = {B[15:0], B[31:16]};
- reload the counter;
- go to HI.
REQ-008 In HI, when the counter reaches 0, the block SHALL capture P_hi = mul_cell_result, set out_result = P_lo + {P_hi[15:0], 16'h0000} mod 2^32, and go to DONE.
REQ-009 out_valid SHALL be 1 exactly while in DONE.
REQ-010 When out_valid and out_ready are both 1, the block SHALL go to IDLE.
REQ-011 While in DONE with out_ready at 0, out_result SHALL be held stable.
REQ-012 Latency SHALL be fixed: with accept at edge E0, out_valid rises after edge E0+2*CELL_LATENCY. For CELL_LATENCY=1 that is after E0+2.
REQ-013 Back-to-back operation SHALL cost one bubble: the next accept happens no earlier than the edge after the handshake edge.
REQ-014 mul_src1 and mul_src2 SHALL hold their last values in IDLE and DONE.
REQ-015 A and B changing on in_src1/in_src2 after accept SHALL have no effect on the operation in progress.
REQ-016 Arithmetic SHALL be unsigned modulo 2^32. Signed operands give the same low word, so no sign handling is needed.
REQ-017 If in_valid is 1 with the FSM outside IDLE, the offer SHALL be ignored and not lost: in_ready stays 0 until IDLE.

Reset
REQ-018 When reset is 1 at an edge, the block SHALL set: state = IDLE, out_valid = 0, out_result = 0, mul_src1 = 0, mul_src2 = 0, counter = 0, P_lo = 0.
REQ-019 Reset SHALL take priority over all handshakes. An operation in progress SHALL be discarded without producing out_valid.
REQ-020 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-021 The macro MUL_SEQ_ZERO_BYPASS_EN SHALL control zero bypass.
- Defined: at accept, if in_src1==0 or in_src2==0, the block goes directly to DONE with out_result=0, so out_valid rises after edge E0. mul_src1 and mul_src2 are not updated.
- Undefined: every operand pair takes the full LO/HI sequence of REQ-012, and no zero-detect logic is synthesized.

Verification
REQ-022 Basic: CELL_LATENCY=1, behavioural cell model; accept 3 x 5 -> out_result=0x0000000F, out_valid after E0+2.
REQ-023 Cross terms: 0x00010003 x 0x00020005 -> 0x000B000F; 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; 0x00010000 x 0x00010000 -> 0x00000000, taking the full sequence when the macro is undefined.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> out_result stable, in_ready=0, second pair accepted only after the handshake and then correct.
REQ-025 Reset mid-op: assert reset in HI -> next cycle out_valid=0, in_ready=1, mul_src1=mul_src2=0; a following 7 x 6 -> 0x0000002A.
REQ-026 Latency sweep: CELL_LATENCY=3 with a 3-cycle cell model; 0x12340000 x 0x00000010 -> 0x23400000, out_valid after E0+6.
REQ-027 Bypass: macro defined, 0 x 0xDEADBEEF -> 0, out_valid after E0 with mul_src unchanged. Macro undefined, the same input -> 0 after E0+2.
